storage_scanner: RTL and testbench

- Read-side initiator for the segment storage block: on `start`, walks addresses 0..length-1 and issues one read per entry.
- Captures each returned position/direction byte pair and presents it downstream on a valid/ready stream, for the renderer and collision checker.
- Never writes storage: the game-logic writer owns `wren`.
- One entry is in flight at a time; the block does not pipeline reads.

---
 rtl/storage_scanner_if.sv | 33 +++
 rtl/storage_scanner.sv | 103 ++++++++++
 tb/tb_storage_scanner.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/storage_scanner_if.sv
// Storage read bus plus the downstream valid/ready pair stream.
// master: scanner side, slave: storage and consumer side.
`timescale 1ns/1ps
interface storage_scanner_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] st_address;
    logic [3:0]        st_mode;
    logic              st_wren;
    logic              st_load_out;
    logic [DATA_W-1:0] st_pos;
    logic [DATA_W-1:0] st_dir;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pos;
    logic [DATA_W-1:0] out_dir;
    logic [ADDR_W-1:0] out_index;

    modport master (
        output st_address, st_mode, st_wren, st_load_out,
        input  st_pos, st_dir,
        output out_valid, out_pos, out_dir, out_index,
        input  out_ready
    );

    modport slave (
        input  st_address, st_mode, st_wren, st_load_out,
        output st_pos, st_dir,
        input  out_valid, out_pos, out_dir, out_index,
        output out_ready
    );
endinterface

// File: rtl/storage_scanner.sv
// Walks storage addresses 0..length-1, one read in flight at a time,
// and streams each position/direction pair out on a valid/ready port.
// Ports: clk, reset (sync, active-high), start/length request,
// busy/done status, bus = storage read bus + output stream (master).
`timescale 1ns/1ps
module storage_scanner #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 8,
    parameter logic [3:0]  MODE_READ = 4'b0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    storage_scanner_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_pos;
    logic [DATA_W-1:0] r_dir;
    logic [ADDR_W-1:0] r_out_index;
    logic              w_hs;
    logic              w_last;

    assign w_hs   = (r_state == S_HOLD) && bus.out_ready;
    // Compare before incrementing so a maximal length never wraps.
    assign w_last = (r_index == r_len - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (length != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = S_HOLD;
            S_HOLD: begin
                if (w_hs) begin
                    w_next = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= '0;
            r_index     <= '0;
            r_pos       <= '0;
            r_dir       <= '0;
            r_out_index <= '0;
        end else begin
            if (r_state == S_IDLE && start && length != '0) begin
                r_len   <= length;
                r_index <= '0;
            end
            // Storage data is valid the cycle after the read strobe.
            if (r_state == S_WAIT) begin
                r_pos       <= bus.st_pos;
                r_dir       <= bus.st_dir;
                r_out_index <= r_index;
            end
            if (w_hs && !w_last) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign bus.st_address  = r_index;
    assign bus.st_mode     = busy ? MODE_READ : 4'b0000;
    assign bus.st_wren     = 1'b0;
    assign bus.st_load_out = (r_state == S_ISSUE);
    assign bus.out_valid   = (r_state == S_HOLD);
    assign bus.out_pos     = r_pos;
    assign bus.out_dir     = r_dir;
    assign bus.out_index   = r_out_index;
endmodule

// File: tb/tb_storage_scanner.sv
// Directed bench for storage_scanner with a small storage model.
// Each scenario task drives a scan and compares against fixed values.
`timescale 1ns/1ps
module tb_storage_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] length = 8'd0;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    storage_scanner_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    storage_scanner #(
        .ADDR_W(8),
        .DATA_W(8),
        .MODE_READ(4'b0001)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .length(length),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_pos [256];
    logic [7:0] mem_dir [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_pos[i] = 8'h10 + 8'(i);
            mem_dir[i] = 8'h80 + 8'(i);
        end
        bus.st_pos = 8'h00;
        bus.st_dir = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.st_load_out) begin
            bus.st_pos <= mem_pos[bus.st_address];
            bus.st_dir <= mem_dir[bus.st_address];
        end
    end

    // Observations gathered by run_scan, judged by the test tasks.
    int         hs_n;
    logic [7:0] hs_idx [16];
    logic [7:0] hs_pos [16];
    logic [7:0] hs_dir [16];
    int         first_valid;
    int         done_n;
    int         done_cyc;
    int         busy_n;
    int         load_n;
    int         valid_n;
    int         wren_n;
    int         stalled;
    logic [7:0] stall_pos [8];
    int         stall_load;
    logic [7:0] abort_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input int len, input int stall_entry,
                            input int stall_n, input int restart_at,
                            input int abort_at, input int max_cyc);
        hs_n = 0; first_valid = -1; done_n = 0; done_cyc = -1;
        busy_n = 0; load_n = 0; valid_n = 0; wren_n = 0;
        stalled = 0; stall_load = 0; abort_addr = 8'hxx;
        length = 8'(len);
        start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c == restart_at) begin
                start = 1'b1;
                length = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (bus.out_valid && hs_n == stall_entry && stalled < stall_n) begin
                bus.out_ready = 1'b0;
                stall_pos[stalled] = bus.out_pos;
                if (bus.st_load_out) stall_load++;
                stalled++;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && first_valid < 0) first_valid = c;
            if (bus.out_valid && bus.out_ready && hs_n < 16) begin
                hs_idx[hs_n] = bus.out_index;
                hs_pos[hs_n] = bus.out_pos;
                hs_dir[hs_n] = bus.out_dir;
                hs_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = c;
            end
            if (busy) busy_n++;
            if (bus.st_load_out) load_n++;
            if (bus.out_valid) valid_n++;
            if (bus.st_wren) wren_n++;
            if (c == abort_at) begin
                abort_addr = bus.st_address;
                reset = 1'b1;
                start = 1'b0;
                tick();
                return;
            end
            tick();
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        length = 8'd4;
        bus.out_ready = 1'b1;
        tick();
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b want=0", done);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.st_load_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes valid=%b load=%b want=0,0",
                     bus.out_valid, bus.st_load_out);
        end
        total++;
        if (bus.st_address !== 8'h00 || bus.st_mode !== 4'h0
            || bus.st_wren !== 1'b0) begin
            bad++;
            $display("FAIL reset_storage addr=%h mode=%h wren=%b want=0,0,0",
                     bus.st_address, bus.st_mode, bus.st_wren);
        end
        total++;
        if (bus.out_pos !== 8'h00 || bus.out_dir !== 8'h00
            || bus.out_index !== 8'h00) begin
            bad++;
            $display("FAIL reset_data pos=%h dir=%h idx=%h want=0,0,0",
                     bus.out_pos, bus.out_dir, bus.out_index);
        end
    endtask

    task automatic test_scan4();
        logic [7:0] e_pos [4];
        logic [7:0] e_dir [4];
        e_pos = '{8'h10, 8'h11, 8'h12, 8'h13};
        e_dir = '{8'h80, 8'h81, 8'h82, 8'h83};
        run_scan(4, -1, 0, -1, -1, 20);
        total++;
        if (hs_n !== 4) begin
            bad++; $display("FAIL scan4_hs_count got=%0d want=4", hs_n);
        end
        for (int k = 0; k < 4 && k < hs_n; k++) begin
            total++;
            if (hs_idx[k] !== 8'(k) || hs_pos[k] !== e_pos[k]
                || hs_dir[k] !== e_dir[k]) begin
                bad++;
                $display("FAIL scan4_entry%0d got=(%h,%h,%h) want=(%h,%h,%h)",
                         k, hs_idx[k], hs_pos[k], hs_dir[k],
                         8'(k), e_pos[k], e_dir[k]);
            end
        end
        total++;
        if (first_valid !== 3) begin
            bad++; $display("FAIL scan4_first_valid got=%0d want=3", first_valid);
        end
        total++;
        if (done_n !== 1 || done_cyc !== 13) begin
            bad++;
            $display("FAIL scan4_done n=%0d cyc=%0d want=1,13", done_n, done_cyc);
        end
        total++;
        if (busy_n !== 13) begin
            bad++; $display("FAIL scan4_busy_cycles got=%0d want=13", busy_n);
        end
        total++;
        if (load_n !== 4 || wren_n !== 0) begin
            bad++;
            $display("FAIL scan4_loads loads=%0d wren=%0d want=4,0", load_n, wren_n);
        end
    endtask

    task automatic test_backpressure();
        run_scan(4, 1, 5, -1, -1, 25);
        total++;
        if (stalled !== 5) begin
            bad++; $display("FAIL bp_stall_cycles got=%0d want=5", stalled);
        end
        for (int k = 0; k < 5 && k < stalled; k++) begin
            total++;
            if (stall_pos[k] !== 8'h11) begin
                bad++; $display("FAIL bp_pos%0d got=%h want=11", k, stall_pos[k]);
            end
        end
        total++;
        if (stall_load !== 0 || load_n !== 4) begin
            bad++;
            $display("FAIL bp_loads during=%0d total=%0d want=0,4",
                     stall_load, load_n);
        end
        total++;
        if (hs_n !== 4 || (hs_n > 1 && hs_pos[1] !== 8'h11)) begin
            bad++;
            $display("FAIL bp_hs n=%0d pos1=%h want=4,11", hs_n, hs_pos[1]);
        end
        total++;
        if (done_n !== 1 || done_cyc !== 18) begin
            bad++;
            $display("FAIL bp_done n=%0d cyc=%0d want=1,18", done_n, done_cyc);
        end
    endtask

    task automatic test_zero_len();
        run_scan(0, -1, 0, -1, -1, 6);
        total++;
        if (done_n !== 1 || done_cyc !== 1) begin
            bad++;
            $display("FAIL zero_done n=%0d cyc=%0d want=1,1", done_n, done_cyc);
        end
        total++;
        if (busy_n !== 1) begin
            bad++; $display("FAIL zero_busy got=%0d want=1", busy_n);
        end
        total++;
        if (load_n !== 0 || valid_n !== 0) begin
            bad++;
            $display("FAIL zero_activity loads=%0d valids=%0d want=0,0",
                     load_n, valid_n);
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        run_scan(4, -1, 0, -1, 8, 20);
        total++;
        if (abort_addr !== 8'h02 || hs_n !== 2) begin
            bad++;
            $display("FAIL mid_abort_point addr=%h hs=%0d want=02,2",
                     abort_addr, hs_n);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0
            || bus.st_load_out !== 1'b0 || bus.st_mode !== 4'h0) begin
            bad++;
            $display("FAIL mid_ctrl busy=%b done=%b valid=%b load=%b mode=%h want=0",
                     busy, done, bus.out_valid, bus.st_load_out, bus.st_mode);
        end
        total++;
        if (bus.st_address !== 8'h00 || bus.out_pos !== 8'h00
            || bus.out_dir !== 8'h00 || bus.out_index !== 8'h00) begin
            bad++;
            $display("FAIL mid_data addr=%h pos=%h dir=%h idx=%h want=0",
                     bus.st_address, bus.out_pos, bus.out_dir, bus.out_index);
        end
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            if (done || busy) dn++;
            tick();
        end
        total++;
        if (dn !== 0) begin
            bad++; $display("FAIL mid_no_done got=%0d want=0", dn);
        end
        run_scan(1, -1, 0, -1, -1, 8);
        total++;
        if (hs_n !== 1 || hs_idx[0] !== 8'h00 || hs_pos[0] !== 8'h10
            || hs_dir[0] !== 8'h80) begin
            bad++;
            $display("FAIL mid_rescan n=%0d got=(%h,%h,%h) want=1,(00,10,80)",
                     hs_n, hs_idx[0], hs_pos[0], hs_dir[0]);
        end
        total++;
        if (done_n !== 1 || done_cyc !== 4) begin
            bad++;
            $display("FAIL mid_rescan_done n=%0d cyc=%0d want=1,4",
                     done_n, done_cyc);
        end
    endtask

    task automatic test_restart_ignored();
        run_scan(4, -1, 0, 5, -1, 30);
        total++;
        if (hs_n !== 4 || load_n !== 4) begin
            bad++;
            $display("FAIL restart_count hs=%0d loads=%0d want=4,4", hs_n, load_n);
        end
        total++;
        if (done_n !== 1 || done_cyc !== 13) begin
            bad++;
            $display("FAIL restart_done n=%0d cyc=%0d want=1,13", done_n, done_cyc);
        end
        total++;
        if (hs_n > 3 && (hs_idx[3] !== 8'h03 || hs_pos[3] !== 8'h13)) begin
            bad++;
            $display("FAIL restart_last got=(%h,%h) want=(03,13)",
                     hs_idx[3], hs_pos[3]);
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_scan4();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_restart_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
